// File: rtl/ntt_pkg.sv
// Shared NTT constants and types, used by plantard_mm, the NTT controller and the butterfly stages.
package ntt_pkg;

    localparam int unsigned Q       = 3329;
    localparam int unsigned W       = 12;
    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned N_BFLY  = 128;
    localparam int unsigned N_STAGE = 7;

    localparam int unsigned BCNT_W = (N_BFLY > 1) ? $clog2(N_BFLY) : 1;
    localparam int unsigned SCNT_W = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

    typedef logic [W-1:0] coef_t;

    // One alignment-line slot: the upper coefficient and whether it is live.
    typedef struct packed {
        logic  vld;
        coef_t coef;
    } line_ent_t;

endpackage

// File: rtl/mod_addsub.sv
// Combinational modular add/subtract: u = (a+p) mod Q, v = (a-p) mod Q for a, p in 0..Q-1.
module mod_addsub
    import ntt_pkg::*;
(
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_p,
    output logic [W-1:0] o_u,
    output logic [W-1:0] o_v
);

    localparam logic [W:0] QExt = (W+1)'(Q);

    logic [W:0] w_sum;
    logic [W:0] w_dif;

    // One conditional correction suffices because both operands are already reduced.
    always_comb begin
        w_sum = {1'b0, i_a} + {1'b0, i_p};
        w_dif = {1'b0, i_a} - {1'b0, i_p};
        o_u   = (w_sum >= QExt) ? W'(w_sum - QExt) : w_sum[W-1:0];
        // Top bit of the difference is the borrow, i.e. a < p.
        o_v   = w_dif[W] ? W'(w_dif + QExt) : w_dif[W-1:0];
    end

endmodule

// File: rtl/ntt_ct_bfly_addsub.sv
// Cooley-Tukey butterfly completion: aligns a with the Plantard product, emits (a+p, a-p) mod Q,
// and counts butterflies to flag end-of-stage and end-of-transform.
module ntt_ct_bfly_addsub
    import ntt_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_a_valid,
    input  logic [W-1:0] i_a_in,
    input  logic         i_p_valid,
    input  logic [W-1:0] i_p_in,
    output logic         o_out_valid,
    output logic [W-1:0] o_u_out,
    output logic [W-1:0] o_v_out,
    output logic         o_stage_done,
    output logic         o_ntt_done,
    output logic         o_align_err
);

    line_ent_t           r_line [MUL_LAT];
    logic [BCNT_W-1:0]   r_bfly_cnt;
    logic [SCNT_W-1:0]   r_stage_cnt;

    line_ent_t           w_tail;
    logic                w_hit;
    logic                w_mis;
    logic                w_last_bfly;
    logic                w_last_stage;
    logic [W-1:0]        w_u;
    logic [W-1:0]        w_v;

    mod_addsub u_mod_addsub (
        .i_a (w_tail.coef),
        .i_p (i_p_in),
        .o_u (w_u),
        .o_v (w_v)
    );

    // Beat decode: the line tail is the a that entered alongside the b producing this p.
    always_comb begin
        w_tail       = r_line[MUL_LAT-1];
        w_hit        = w_tail.vld & i_p_valid;
        w_mis        = w_tail.vld ^ i_p_valid;
        w_last_bfly  = (r_bfly_cnt == BCNT_W'(N_BFLY - 1));
        w_last_stage = (r_stage_cnt == SCNT_W'(N_STAGE - 1));
    end

    // Alignment shift register, advancing every cycle; clr flushes it to invalid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(MUL_LAT); i++) begin
                r_line[i] <= '0;
            end
        end else if (i_clr) begin
            for (int i = 0; i < int'(MUL_LAT); i++) begin
                r_line[i] <= '0;
            end
        end else begin
            r_line[0] <= '{vld: i_a_valid, coef: i_a_in};
            for (int i = 1; i < int'(MUL_LAT); i++) begin
                r_line[i] <= r_line[i-1];
            end
        end
    end

    // Output register: data only updates on an emitted beat, so u/v hold across idle cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_out_valid  <= 1'b0;
            o_u_out      <= '0;
            o_v_out      <= '0;
            o_stage_done <= 1'b0;
            o_ntt_done   <= 1'b0;
        end else if (i_clr) begin
            o_out_valid  <= 1'b0;
            o_stage_done <= 1'b0;
            o_ntt_done   <= 1'b0;
        end else begin
            o_out_valid  <= w_hit;
            o_stage_done <= w_hit & w_last_bfly;
            o_ntt_done   <= w_hit & w_last_bfly & w_last_stage;
            if (w_hit) begin
                o_u_out <= w_u;
                o_v_out <= w_v;
            end
        end
    end

    // Butterfly and stage counters; only emitted beats advance them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bfly_cnt  <= '0;
            r_stage_cnt <= '0;
        end else if (i_clr) begin
            r_bfly_cnt  <= '0;
            r_stage_cnt <= '0;
        end else if (w_hit) begin
            if (w_last_bfly) begin
                r_bfly_cnt  <= '0;
                r_stage_cnt <= w_last_stage ? '0 : r_stage_cnt + SCNT_W'(1);
            end else begin
                r_bfly_cnt  <= r_bfly_cnt + BCNT_W'(1);
            end
        end
    end

    // Sticky alignment error; survives clr so the controller can still see it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_align_err <= 1'b0;
        end else if (w_mis) begin
            o_align_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ntt_ct_bfly_addsub.sv
// Directed bench for ntt_ct_bfly_addsub; the bench plays plantard_mm by delaying p by MUL_LAT.
module tb_ntt_ct_bfly_addsub;
    import ntt_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         clr = 1'b0;
    logic         a_valid = 1'b0;
    logic [W-1:0] a_in = '0;
    logic         p_valid = 1'b0;
    logic [W-1:0] p_in = '0;
    logic         out_valid;
    logic [W-1:0] u_out;
    logic [W-1:0] v_out;
    logic         stage_done;
    logic         ntt_done;
    logic         align_err;

    ntt_ct_bfly_addsub dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clr        (clr),
        .i_a_valid    (a_valid),
        .i_a_in       (a_in),
        .i_p_valid    (p_valid),
        .i_p_in       (p_in),
        .o_out_valid  (out_valid),
        .o_u_out      (u_out),
        .o_v_out      (v_out),
        .o_stage_done (stage_done),
        .o_ntt_done   (ntt_done),
        .o_align_err  (align_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Bench-side product pipe: index k holds what was issued k cycles ago.
    logic pv_pipe [MUL_LAT+1];
    int   pa_pipe [MUL_LAT+1];
    int   pp_pipe [MUL_LAT+1];

    // Reference state.
    int m_bfly = 0, m_stage = 0, m_u = 0, m_v = 0;
    logic m_err = 1'b0;

    // Per-run observations.
    int emit_n = 0, n_sd = 0, n_nd = 0, first_sd = -1, nd_at = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_pipe();
        for (int i = 0; i <= int'(MUL_LAT); i++) begin
            pv_pipe[i] = 1'b0;
            pa_pipe[i] = 0;
            pp_pipe[i] = 0;
        end
    endtask

    task automatic new_run();
        emit_n = 0; n_sd = 0; n_nd = 0; first_sd = -1; nd_at = -1;
    endtask

    // One clock: issue (av,a,p), deliver the product issued MUL_LAT cycles ago, check outputs.
    task automatic tick(input logic av, input int a, input int p, input logic inj, input logic c);
        logic hit, mis, exp_sd, exp_nd;
        for (int i = int'(MUL_LAT); i > 0; i--) begin
            pv_pipe[i] = pv_pipe[i-1];
            pa_pipe[i] = pa_pipe[i-1];
            pp_pipe[i] = pp_pipe[i-1];
        end
        pv_pipe[0] = av;
        pa_pipe[0] = a;
        pp_pipe[0] = p;
        a_valid = av;
        a_in    = W'(a);
        p_valid = pv_pipe[MUL_LAT] | inj;
        p_in    = W'(pp_pipe[MUL_LAT]);
        clr     = c;
        @(posedge clk);
        #1;
        hit = pv_pipe[MUL_LAT] & ~c;
        mis = inj & ~pv_pipe[MUL_LAT];
        exp_sd = 1'b0;
        exp_nd = 1'b0;
        if (mis) m_err = 1'b1;
        if (c) begin
            m_bfly = 0;
            m_stage = 0;
        end else if (hit) begin
            m_u = (pa_pipe[MUL_LAT] + pp_pipe[MUL_LAT]) % int'(Q);
            m_v = (pa_pipe[MUL_LAT] - pp_pipe[MUL_LAT] + int'(Q)) % int'(Q);
            exp_sd = (m_bfly == int'(N_BFLY) - 1);
            exp_nd = exp_sd && (m_stage == int'(N_STAGE) - 1);
            m_bfly = exp_sd ? 0 : m_bfly + 1;
            if (exp_sd) m_stage = exp_nd ? 0 : m_stage + 1;
        end
        chk("out_valid", 32'(out_valid), 32'(hit));
        chk("u_out", 32'(u_out), 32'(m_u));
        chk("v_out", 32'(v_out), 32'(m_v));
        chk("stage_done", 32'(stage_done), 32'(exp_sd));
        chk("ntt_done", 32'(ntt_done), 32'(exp_nd));
        chk("align_err", 32'(align_err), 32'(m_err));
        if (hit) emit_n++;
        if (stage_done === 1'b1) begin
            n_sd++;
            if (first_sd < 0) first_sd = emit_n;
        end
        if (ntt_done === 1'b1) begin
            n_nd++;
            nd_at = emit_n;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, (i * 37 + 5) % int'(Q), (i * 101 + 9) % int'(Q), 1'b0, 1'b0);
        end
    endtask

    initial begin
        clear_pipe();
        #1 rst_n = 1'b0;
        #11;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_u", 32'(u_out), 32'd0);
        chk("rst_v", 32'(v_out), 32'd0);
        chk("rst_stage_done", 32'(stage_done), 32'd0);
        chk("rst_ntt_done", 32'(ntt_done), 32'd0);
        chk("rst_align_err", 32'(align_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single aligned beat: result appears the cycle after p_valid, then holds.
        tick(1'b1, 100, 200, 1'b0, 1'b0);
        idle(int'(MUL_LAT) - 1);
        chk("t1_early", 32'(out_valid), 32'd0);
        idle(1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_u", 32'(u_out), 32'd300);
        chk("t1_v", 32'(v_out), 32'd3229);
        idle(1);
        chk("t1_drop", 32'(out_valid), 32'd0);
        chk("t1_hold_u", 32'(u_out), 32'd300);

        // Wrap-around corners, back to back.
        tick(1'b1, 3000, 1000, 1'b0, 1'b0);
        tick(1'b1, 3328, 3328, 1'b0, 1'b0);
        tick(1'b1, 0, 0, 1'b0, 1'b0);
        idle(int'(MUL_LAT) - 2);
        chk("t2a_u", 32'(u_out), 32'd671);
        chk("t2a_v", 32'(v_out), 32'd2000);
        idle(1);
        chk("t2b_u", 32'(u_out), 32'd3327);
        chk("t2b_v", 32'(v_out), 32'd0);
        idle(1);
        chk("t2c_u", 32'(u_out), 32'd0);
        chk("t2c_v", 32'(v_out), 32'd0);
        idle(1);

        // Full transform from zeroed counters, then one more stage to show both wrapped.
        tick(1'b0, 0, 0, 1'b0, 1'b1);
        new_run();
        stream(int'(N_BFLY * N_STAGE));
        idle(int'(MUL_LAT));
        chk("t3_first_sd", 32'(first_sd), 32'd128);
        chk("t3_n_sd", 32'(n_sd), 32'd7);
        chk("t3_n_nd", 32'(n_nd), 32'd1);
        chk("t3_nd_at", 32'(nd_at), 32'd896);
        new_run();
        stream(int'(N_BFLY));
        idle(int'(MUL_LAT));
        chk("t3_wrap_sd", 32'(first_sd), 32'd128);
        chk("t3_wrap_nd", 32'(n_nd), 32'd0);

        // Orphan product: error flagged, nothing emitted, sticky through clr.
        tick(1'b0, 0, 0, 1'b1, 1'b0);
        chk("t4_err", 32'(align_err), 32'd1);
        chk("t4_no_valid", 32'(out_valid), 32'd0);
        tick(1'b0, 0, 0, 1'b0, 1'b1);
        chk("t4_err_after_clr", 32'(align_err), 32'd1);

        // 50 counted beats, then clr lands on the 51st product.
        new_run();
        stream(51);
        idle(int'(MUL_LAT) - 1);
        tick(1'b0, 0, 0, 1'b0, 1'b1);
        chk("t5_clr_drop", 32'(out_valid), 32'd0);
        chk("t5_emitted", 32'(emit_n), 32'd50);
        new_run();
        stream(int'(N_BFLY));
        idle(int'(MUL_LAT));
        chk("t5_fresh_sd", 32'(first_sd), 32'd128);
        chk("t5_n_sd", 32'(n_sd), 32'd1);

        // Async reset with beats in flight.
        stream(5);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_u", 32'(u_out), 32'd0);
        chk("t6_v", 32'(v_out), 32'd0);
        chk("t6_sd", 32'(stage_done), 32'd0);
        chk("t6_nd", 32'(ntt_done), 32'd0);
        chk("t6_err", 32'(align_err), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_pipe();
        m_bfly = 0; m_stage = 0; m_u = 0; m_v = 0; m_err = 1'b0;
        new_run();
        idle(int'(MUL_LAT) + 2);
        chk("t6_no_spurious", 32'(emit_n), 32'd0);
        stream(int'(N_BFLY));
        idle(int'(MUL_LAT));
        chk("t6_restart_sd", 32'(first_sd), 32'd128);
        chk("t6_restart_n_sd", 32'(n_sd), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
